// File: rtl/riscv_prefetch_obi_buffer.sv
// Instruction prefetch buffer: OBI-style fetch port towards instruction memory,
// small in-order FIFO, valid/ready delivery to the IF stage, branch redirect
// with discard of stale responses, and sticky PMP fetch fault reporting.
module riscv_prefetch_obi_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_pmp_i,
  output logic        fetch_failed_o,
  output logic        busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e             r_state;
  logic [31:0]        r_fetch_addr;
  logic [31:0]        r_hold_addr;
  logic [31:0]        r_rsp_addr;
  logic [OUT_W-1:0]   r_out_cnt;
  logic [OUT_W-1:0]   r_discard_cnt;
  logic [CNT_W-1:0]   r_fifo_cnt;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic               r_first;
  logic               r_fault;
  logic               r_stale;
  logic [31:0]        r_mem_data [DEPTH];
  logic [31:0]        r_mem_addr [DEPTH];

  logic               w_held;
  logic [31:0]        w_tgt_addr;
  logic [CNT_W-1:0]   w_fifo_eff;
  logic               w_credit_ok;
  logic               w_new_req;
  logic               w_gnt;
  logic               w_stale_gnt;
  logic               w_stale_ok;
  logic               w_fresh_ok;
  logic               w_fresh_err;
  logic               w_out_inc;
  logic               w_rvalid;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_push_addr;

  // Request generation: a held request always stays up; a new one needs credit.
  // In the branch cycle the FIFO is about to be flushed, so it does not count.
  assign w_held      = (r_state == S_HOLD);
  assign w_tgt_addr  = {addr_i[31:2], 2'b00};
  assign w_fifo_eff  = branch_i ? '0 : r_fifo_cnt;
  assign w_credit_ok = (r_out_cnt < OUT_W'(MAX_OUTSTANDING)) &&
                       ((SUM_W'(w_fifo_eff) + SUM_W'(r_out_cnt)) < SUM_W'(DEPTH));
  assign w_new_req   = req_i && w_credit_ok &&
                       (branch_i || ((r_state == S_FETCH) && !r_fault));
  assign instr_req_o  = w_held || w_new_req;
  assign instr_addr_o = w_held ? r_hold_addr : (branch_i ? w_tgt_addr : r_fetch_addr);

  // Grant classification: a held request granted on or after a branch is stale.
  assign w_gnt       = instr_req_o && instr_gnt_i;
  assign w_stale_gnt = w_gnt && w_held && (r_stale || branch_i);
  assign w_stale_ok  = w_stale_gnt && !instr_err_pmp_i;
  assign w_fresh_ok  = w_gnt && !w_stale_gnt && !instr_err_pmp_i;
  assign w_fresh_err = w_gnt && !w_stale_gnt && instr_err_pmp_i;
  assign w_out_inc   = w_fresh_ok || w_stale_ok;

  // Response handling: responses with nothing outstanding (e.g. after reset) are ignored.
  assign w_rvalid    = instr_rvalid_i && (r_out_cnt != '0);
  assign w_drop      = w_rvalid && (r_discard_cnt != '0);
  assign w_push      = w_rvalid && !w_drop && !branch_i;
  assign w_pop       = valid_o && ready_i;
  assign w_push_addr = r_first ? r_rsp_addr : {r_rsp_addr[31:2], 2'b00};

  assign valid_o        = (r_fifo_cnt != '0);
  assign rdata_o        = r_mem_data[r_rptr];
  assign addr_o         = r_mem_addr[r_rptr];
  assign fetch_failed_o = r_fault;
  assign busy_o         = instr_req_o || (r_out_cnt != '0);

  // Fetch FSM, transaction counters, fetch address and fault tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_addr  <= '0;
      r_hold_addr   <= '0;
      r_rsp_addr    <= '0;
      r_out_cnt     <= '0;
      r_discard_cnt <= '0;
      r_first       <= 1'b0;
      r_fault       <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      if (w_held) begin
        r_state <= instr_gnt_i ? S_FETCH : S_HOLD;
      end else if (instr_req_o && !instr_gnt_i) begin
        r_state <= S_HOLD;
      end else if (branch_i || (r_state == S_FETCH)) begin
        r_state <= S_FETCH;
      end else begin
        r_state <= S_IDLE;
      end

      if (!w_held && instr_req_o && !instr_gnt_i) begin
        r_hold_addr <= instr_addr_o;
      end
      r_stale <= w_held && !instr_gnt_i && (r_stale || branch_i);

      r_out_cnt <= r_out_cnt + OUT_W'(w_out_inc) - OUT_W'(w_rvalid);

      if (branch_i) begin
        r_discard_cnt <= r_out_cnt - OUT_W'(w_rvalid) + OUT_W'(w_stale_ok);
      end else begin
        r_discard_cnt <= r_discard_cnt - OUT_W'(w_drop) + OUT_W'(w_stale_ok);
      end

      if (branch_i) begin
        r_fetch_addr <= w_fresh_ok ? (w_tgt_addr + 32'd4) : w_tgt_addr;
      end else if (w_fresh_ok) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
      end

      if (w_fresh_err) begin
        r_fault <= 1'b1;
      end else if (branch_i) begin
        r_fault <= 1'b0;
      end

      if (branch_i) begin
        r_first    <= 1'b1;
        r_rsp_addr <= addr_i;
      end else if (w_push) begin
        r_first    <= 1'b0;
        r_rsp_addr <= r_rsp_addr + 32'd4;
      end
    end
  end

  // Word FIFO: registered storage, flushed on branch, push/pop may coincide when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_data[i] <= '0;
        r_mem_addr[i] <= '0;
      end
    end else if (branch_i) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= instr_rdata_i;
        r_mem_addr[r_wptr] <= w_push_addr;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // The credit rule must make a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_fifo_cnt == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_riscv_prefetch_obi_buffer.sv
// Bench for the prefetch buffer: OBI memory model with configurable latency,
// grant stall and PMP denial; scoreboard queue checked by a pop monitor.
module tb_riscv_prefetch_obi_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_pmp_i;
  logic        fetch_failed_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_prefetch_obi_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .branch_i        (branch_i),
    .addr_i          (addr_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .rdata_o         (rdata_o),
    .addr_o          (addr_o),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_err_pmp_i (instr_err_pmp_i),
    .fetch_failed_o  (fetch_failed_o),
    .busy_o          (busy_o)
  );

  // Memory model controls
  int unsigned lat      = 1;
  logic        gnt_en   = 1'b1;
  logic        pmp_en   = 1'b0;
  logic [31:0] pmp_addr = 32'h0000_0300;
  int unsigned cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  rsp_t        pend_q[$];
  logic [31:0] gnt_log[$];
  exp_t        exp_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_5A3C;
  endfunction

  assign instr_gnt_i     = instr_req_o & gnt_en;
  assign instr_err_pmp_i = instr_gnt_i & pmp_en & (instr_addr_o == pmp_addr);

  // Record accepted (non-denied) grants mid-cycle
  always @(negedge clk) begin
    if (rst_n && instr_req_o && instr_gnt_i && !instr_err_pmp_i) begin
      gnt_log.push_back(instr_addr_o);
      pend_q.push_back('{addr: instr_addr_o, due: cyc + lat});
    end
  end

  // Return responses in order after the configured latency
  initial begin
    rsp_t r;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_data(r.addr);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end
    end
  end

  // Pop monitor: every accepted word outside a branch cycle must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_o && ready_i && !branch_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: addr_o=%h rdata_o=%h with no word expected", addr_o, rdata_o);
      end else begin
        e = exp_q.pop_front();
        if (addr_o !== e.addr || rdata_o !== e.data) begin
          failures++;
          $display("FAIL pop_word: got addr=%h data=%h, expected addr=%h data=%h",
                   addr_o, rdata_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_q.push_back('{addr: a, data: mem_data({a[31:2], 2'b00})});
  endtask

  task automatic wait_queue(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d words still expected after %0d cycles", name, exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy_o && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    req_i    = 1'b0;
    branch_i = 1'b0;
    addr_i   = '0;
    ready_i  = 1'b0;
    step(2);
    chk("rst_valid",   32'(valid_o),        32'd0);
    chk("rst_req",     32'(instr_req_o),    32'd0);
    chk("rst_busy",    32'(busy_o),         32'd0);
    chk("rst_fault",   32'(fetch_failed_o), 32'd0);
    chk("rst_addr_o",  addr_o,              32'd0);
    chk("rst_iaddr",   instr_addr_o,        32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_req", 32'(instr_req_o),    32'd0);

    // Boot: zero-wait memory, ready high
    lat = 1; gnt_en = 1'b1; ready_i = 1'b1; req_i = 1'b1;
    expect_word(32'h1C00_0080);
    expect_word(32'h1C00_0084);
    expect_word(32'h1C00_0088);
    base = gnt_log.size();
    branch_i = 1'b1; addr_i = 32'h1C00_0080;
    #1;
    chk("boot_req_T",   32'(instr_req_o), 32'd1);
    chk("boot_iaddr_T", instr_addr_o,     32'h1C00_0080);
    step();
    branch_i = 1'b0;
    #1;
    chk("boot_valid_T1", 32'(valid_o), 32'd0);
    step();
    #1;
    chk("boot_valid_T2", 32'(valid_o), 32'd1);
    chk("boot_addr_T2",  addr_o,       32'h1C00_0080);
    wait_queue("boot_words", 20);
    ready_i = 1'b0;
    chk("boot_gnt0", gnt_log[base],     32'h1C00_0080);
    chk("boot_gnt1", gnt_log[base + 1], 32'h1C00_0084);
    chk("boot_gnt2", gnt_log[base + 2], 32'h1C00_0088);

    // Back-pressure: FIFO fills to DEPTH and requests stop
    step(10);
    chk("bp_req_low",  32'(instr_req_o), 32'd0);
    chk("bp_busy_low", 32'(busy_o),      32'd0);
    chk("bp_valid",    32'(valid_o),     32'd1);
    chk("bp_head",     addr_o,           32'h1C00_008C);
    chk("bp_gnt_cnt",  32'(gnt_log.size() - base), 32'd7);
    req_i = 1'b0;
    expect_word(32'h1C00_008C);
    expect_word(32'h1C00_0090);
    expect_word(32'h1C00_0094);
    expect_word(32'h1C00_0098);
    ready_i = 1'b1;
    wait_queue("bp_words", 20);
    ready_i = 1'b0;
    step(2);
    chk("bp_drained", 32'(valid_o), 32'd0);

    // Branch with two outstanding, latency 3
    lat = 3;
    base = gnt_log.size();
    expect_word(32'h0000_0200);
    expect_word(32'h0000_0204);
    expect_word(32'h0000_0208);
    req_i = 1'b1;
    #1;
    chk("br2_iaddr", instr_addr_o, 32'h1C00_009C);
    step(2);
    chk("br2_req_full", 32'(instr_req_o), 32'd0);
    chk("br2_busy",     32'(busy_o),      32'd1);
    branch_i = 1'b1; addr_i = 32'h0000_0200; ready_i = 1'b1;
    #1;
    chk("br2_req_branch", 32'(instr_req_o), 32'd0);
    step();
    branch_i = 1'b0;
    wait_queue("br2_words", 40);
    ready_i = 1'b0;
    chk("br2_gnt0", gnt_log[base],     32'h1C00_009C);
    chk("br2_gnt1", gnt_log[base + 1], 32'h1C00_00A0);
    chk("br2_gnt2", gnt_log[base + 2], 32'h0000_0200);
    req_i = 1'b0;
    wait_idle("br2_drain", 40);

    // Held request across req_i drop and branch
    lat = 1; gnt_en = 1'b0; req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0040;
    #1;
    chk("hold_req0",  32'(instr_req_o), 32'd1);
    chk("hold_addr0", instr_addr_o,     32'h0000_0040);
    step();
    branch_i = 1'b0; req_i = 1'b0;
    #1;
    chk("hold_req_noreq", 32'(instr_req_o), 32'd1);
    chk("hold_addr1",     instr_addr_o,     32'h0000_0040);
    step();
    base = gnt_log.size();
    expect_word(32'h0000_0102);
    expect_word(32'h0000_0104);
    expect_word(32'h0000_0108);
    branch_i = 1'b1; addr_i = 32'h0000_0102; req_i = 1'b1;
    #1;
    chk("hold_addr_br", instr_addr_o, 32'h0000_0040);
    step();
    branch_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("hold_addr_after", instr_addr_o,     32'h0000_0040);
    chk("hold_req_after",  32'(instr_req_o), 32'd1);
    step();
    gnt_en = 1'b1;
    wait_queue("hold_words", 30);
    ready_i = 1'b0;
    chk("hold_gnt0", gnt_log[base],     32'h0000_0040);
    chk("hold_gnt1", gnt_log[base + 1], 32'h0000_0100);
    req_i = 1'b0;
    wait_idle("hold_drain", 40);

    // PMP fault and recovery
    pmp_en = 1'b1; req_i = 1'b1;
    base = gnt_log.size();
    branch_i = 1'b1; addr_i = 32'h0000_0300;
    #1;
    chk("pmp_req",   32'(instr_req_o), 32'd1);
    chk("pmp_iaddr", instr_addr_o,     32'h0000_0300);
    step();
    branch_i = 1'b0;
    #1;
    chk("pmp_fault_set", 32'(fetch_failed_o), 32'd1);
    chk("pmp_req_stop",  32'(instr_req_o),    32'd0);
    chk("pmp_busy",      32'(busy_o),         32'd0);
    step(4);
    chk("pmp_still_stop",  32'(instr_req_o),    32'd0);
    chk("pmp_still_fault", 32'(fetch_failed_o), 32'd1);
    chk("pmp_no_gnt",      32'(gnt_log.size() - base), 32'd0);
    expect_word(32'h0000_0400);
    expect_word(32'h0000_0404);
    branch_i = 1'b1; addr_i = 32'h0000_0400;
    #1;
    chk("pmp_resume_req",  32'(instr_req_o), 32'd1);
    chk("pmp_resume_addr", instr_addr_o,     32'h0000_0400);
    step();
    branch_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("pmp_fault_clr", 32'(fetch_failed_o), 32'd0);
    wait_queue("pmp_words", 30);
    ready_i = 1'b0; req_i = 1'b0; pmp_en = 1'b0;
    wait_idle("pmp_drain", 40);

    // Reset with two outstanding; late responses must be ignored
    lat = 3; req_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h0000_0500;
    step();
    branch_i = 1'b0;
    step();
    chk("rst2_busy",    32'(busy_o),      32'd1);
    chk("rst2_req_out", 32'(instr_req_o), 32'd0);
    rst_n = 1'b0; req_i = 1'b0;
    #1;
    chk("rst2_req",   32'(instr_req_o),    32'd0);
    chk("rst2_busy0", 32'(busy_o),         32'd0);
    chk("rst2_valid", 32'(valid_o),        32'd0);
    chk("rst2_fault", 32'(fetch_failed_o), 32'd0);
    chk("rst2_addr",  addr_o,              32'd0);
    chk("rst2_rdata", rdata_o,             32'd0);
    step();
    rst_n = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst2_late_valid", 32'(valid_o), 32'd0);
    end
    chk("rst2_late_busy", 32'(busy_o), 32'd0);
    ready_i = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/riscv_prefetch_obi_buffer.md
# riscv_prefetch_obi_buffer

Instruction prefetch buffer between the instruction memory port (OBI-style req/gnt/rvalid) and the IF stage. Issues word-aligned fetch requests with up to two transactions in flight, stores returned words in a small FIFO, and delivers them to the IF stage over a valid/ready handshake. On a branch it flushes buffered words, discards stale responses and redirects fetching. It also reports PMP fetch faults.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- MAX_OUTSTANDING, 2: max granted-but-not-returned requests; 1 or 2.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  fetch enable from the core
- branch_i  in  1  redirect; one-cycle pulse
- addr_i  in  32  branch target, halfword aligned (bit 0 = 0)
- ready_i  in  1  IF stage consumes the head word
- valid_o  out  1  head word valid
- rdata_o  out  32  head word
- addr_o  out  32  address of head word
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  memory address, bits [1:0] = 0
- instr_gnt_i  in  1  request granted
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- instr_err_pmp_i  in  1  PMP denial, qualified by instr_gnt_i
- fetch_failed_o  out  1  sticky PMP fault flag
- busy_o  out  1  request or outstanding transaction pending

## Operation
- Registers: fetch_addr_q (next word to request), out_cnt (0..MAX_OUTSTANDING), discard_cnt (0..MAX_OUTSTANDING), fifo_cnt (0..DEPTH), first_q (next stored word is the first after a branch), fault_q.
- FSM states:
  - IDLE: no request. Go to FETCH on branch_i.
  - FETCH: instr_req_o = 1 when all of: req_i, !fault_q, out_cnt < MAX_OUTSTANDING, fifo_cnt + out_cnt < DEPTH.
  - HOLD: request presented but not granted. instr_req_o stays 1 and instr_addr_o stays stable until grant (OBI rule), even across branch_i or req_i deassertion. On grant go to FETCH.
- Grant without error: out_cnt++, fetch_addr_q += 4.
- Grant with instr_err_pmp_i: out_cnt is not incremented; fault_q and fetch_failed_o are set; requests stop until the next branch_i.
- rvalid:
  - discard_cnt > 0: drop the word, discard_cnt--.
  - Otherwise push {instr_rdata_i, address} into the FIFO.
  - out_cnt-- in both cases.
- Stored address:
  - First word after a branch: addr_i as given, bit 1 may be set; the downstream aligner uses it.
  - Later words: word aligned.
- branch_i, applied at the clock edge:
  - Flush FIFO (fifo_cnt = 0).
  - discard_cnt = out_cnt − (rvalid this cycle) + (held request granted this cycle).
  - A held request still ungranted after the branch edge is marked stale; its response is discarded when it returns.
  - fetch_addr_q = {addr_i[31:2], 2'b00}; first_q = 1; fault_q and fetch_failed_o cleared.
- If no request is held in the branch cycle, instr_addr_o = {addr_i[31:2], 2'b00} combinationally in that same cycle.
- Pop when valid_o && ready_i.
- Push and pop in the same cycle on a full FIFO is legal. The pop frees space for the push.
- busy_o = instr_req_o | (out_cnt != 0).
- Reset values: all outputs 0; state IDLE; all counters 0.

## Timing
- Request is combinational from state and counters; address comes from fetch_addr_q, or from addr_i in the branch cycle.
- rvalid in cycle N → valid_o = 1 in N+1. The FIFO is registered, with no bypass.
- With zero-wait memory (gnt same cycle, rvalid next cycle), branch_i at T gives: request at T, rvalid at T+1, valid_o at T+2.
- valid_o in the branch_i cycle reflects pre-branch contents; the consumer ignores it. From T+1, valid_o = 0 until new data arrives.
- The back-pressure credit rule guarantees no push is lost; overflow is an assertion failure.
- req_i deasserted: no new requests. Outstanding responses are still stored; a held request completes.
- Reset mid-transaction: all state cleared. Late rvalid after reset is ignored, because out_cnt = 0 and nothing is pushed.

## Test plan
- Boot: branch_i with addr_i = 0x1C00_0080, zero-wait memory, ready_i = 1 → requests to 0x80, 0x84, 0x88…; valid_o from T+2; addr_o sequence 0x80, 0x84, 0x88.
- Back-pressure: ready_i = 0 for 10 cycles, DEPTH = 4 → exactly 4 words buffered, instr_req_o low; on release, words come out in order with none lost.
- Branch with 2 outstanding: memory latency 3, branch_i to 0x200 → both old responses dropped; first valid_o has addr_o = 0x200.
- Held request: gnt stalled with instr_addr_o = 0x40, branch_i to 0x102 → 0x40 is held until gnt and its data discarded; next request is 0x100; first addr_o = 0x102.
- PMP: gnt with instr_err_pmp_i on 0x300 → fetch_failed_o = 1 next cycle, no further requests; branch_i clears it and fetching resumes.
- Reset asserted with out_cnt = 2 → all outputs 0 immediately; late rvalid ignored (valid_o stays 0).
